// File: rtl/pattern_gen_pkg.sv
// Types, dimensions and helpers shared by the test-pattern generator and its rainbow mapper.
package pattern_gen_pkg;

`include "vga.svh"

  localparam int H_BITS = `H_SIZE;
  localparam int H_DISP = `H_DISPLAY;
  localparam int V_DISP = `V_DISPLAY;

  typedef enum logic [2:0] {
    MODE_GRAY    = 3'd0,
    MODE_PRIMARY = 3'd1,
    MODE_RAINBOW = 3'd2,
    MODE_CHECKER = 3'd3,
    MODE_TRIBAND = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    BAND_TOP = 2'd0,
    BAND_MID = 2'd1,
    BAND_LOW = 2'd2
  } band_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;

  localparam rgb4_t RGB4_WHITE = 12'hFFF;
  localparam rgb4_t RGB4_BLACK = 12'h000;

  // MSB-first replication; callers keep the top RGB_WIDTH bits.
  function automatic logic [31:0] expandIntensity(input logic [3:0] v);
    return {8{v}};
  endfunction

endpackage

// File: rtl/pattern_rainbow.sv
// Maps an effective x coordinate onto a six-segment colour ramp, white past the last segment.
module pattern_rainbow
  import pattern_gen_pkg::*;
(
  input  logic [H_BITS-1:0] xe_i,
  output rgb4_t             rgb_o
);

  logic [2:0] seg;
  logic [3:0] up;
  logic [3:0] dn;
  logic       unusedLowBits;

  assign seg           = xe_i[9:7];
  assign up            = xe_i[6:3];
  assign dn            = 4'hF - up;
  assign unusedLowBits = ^xe_i[2:0];

  always_comb begin
    rgb_o = RGB4_WHITE;
    case (seg)
      3'd0:    rgb_o = '{r: 4'hF, g: up,   b: 4'h0};
      3'd1:    rgb_o = '{r: dn,   g: 4'hF, b: 4'h0};
      3'd2:    rgb_o = '{r: 4'h0, g: 4'hF, b: up};
      3'd3:    rgb_o = '{r: 4'h0, g: dn,   b: 4'hF};
      3'd4:    rgb_o = '{r: up,   g: 4'h0, b: 4'hF};
      3'd5:    rgb_o = '{r: 4'hF, g: 4'h0, b: dn};
      default: rgb_o = RGB4_WHITE;
    endcase
  end

endmodule

// File: rtl/vga.svh
// Shared VGA timing dimensions for the 640x480 display.
`ifndef VGA_SVH
`define VGA_SVH
`define H_SIZE    10
`define H_DISPLAY 640
`define V_DISPLAY 480
`endif

// File: rtl/pattern_gen.sv
// Two-stage VGA test-pattern generator with frame-synchronous mode latching and horizontal scroll.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int RGB_WIDTH   = 8,
  parameter int SCROLL_STEP = 4,
  parameter int CHECK_LOG2  = 5
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  input  logic                 vga_hsync,
  input  logic                 vga_vsync,
  input  logic                 video_on,
  input  logic [H_BITS-1:0]    x_addr,
  input  logic [H_BITS-1:0]    y_addr,
  input  logic [2:0]           mode,
  input  logic                 scroll_en,
  output logic [RGB_WIDTH-1:0] R,
  output logic [RGB_WIDTH-1:0] G,
  output logic [RGB_WIDTH-1:0] B,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic                 DISPLAY,
  output logic [15:0]          frame_cnt
);

  logic              vsyncHist_q;
  logic              frameStart_q, frameStart_d;
  logic [H_BITS-1:0] offset_q, offset_d;
  logic [H_BITS:0]   offsetSum;
  mode_e             activeMode_q, activeMode_d;
  logic [15:0]       frameCnt_q, frameCnt_d;

  logic [H_BITS-1:0] xe1_q, xe1_d;
  logic [H_BITS:0]   xeSum;
  band_e             band1_q, band1_d;
  logic              checker1_q, checker1_d;
  mode_e             mode1_q;
  logic              hs1_q, vs1_q, de1_q;

  logic [RGB_WIDTH-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic                 hs2_q, vs2_q, de2_q;

  rgb4_t       rainbowPix, grayPix, primaryPix, pix;
  logic [31:0] rWide, gWide, bWide;
  logic        unusedExpBits;

  // Frame bookkeeping acts the cycle after the vsync fall is seen, long before visible pixels.
  always_comb begin
    frameStart_d = vsyncHist_q & ~vga_vsync;
    offset_d     = offset_q;
    activeMode_d = activeMode_q;
    frameCnt_d   = frameCnt_q;
    offsetSum    = {1'b0, offset_q} + (H_BITS+1)'(SCROLL_STEP);
    if (frameStart_q) begin
      frameCnt_d   = frameCnt_q + 16'd1;
      activeMode_d = mode_e'(mode);
      if (scroll_en) begin
        offset_d = (offsetSum >= (H_BITS+1)'(H_DISP)) ?
                   H_BITS'(offsetSum - (H_BITS+1)'(H_DISP)) : H_BITS'(offsetSum);
      end
    end
  end

  always_comb begin
    xeSum      = {1'b0, x_addr} + {1'b0, offset_q};
    xe1_d      = (xeSum >= (H_BITS+1)'(H_DISP)) ?
                 H_BITS'(xeSum - (H_BITS+1)'(H_DISP)) : H_BITS'(xeSum);
    checker1_d = x_addr[CHECK_LOG2] ^ y_addr[CHECK_LOG2];
    band1_d    = BAND_LOW;
    if (y_addr < H_BITS'(V_DISP / 3)) begin
      band1_d = BAND_TOP;
    end else if (y_addr < H_BITS'(2 * V_DISP / 3)) begin
      band1_d = BAND_MID;
    end
  end

  pattern_rainbow u_rainbow (
    .xe_i  (xe1_q),
    .rgb_o (rainbowPix)
  );

  assign grayPix    = {xe1_q[8:5], xe1_q[8:5], xe1_q[8:5]};
  assign primaryPix = {{4{xe1_q[8]}}, {4{xe1_q[7]}}, {4{xe1_q[6]}}};

  // Unassigned mode codes fall through to white.
  always_comb begin
    pix = RGB4_WHITE;
    case (mode1_q)
      MODE_GRAY:    pix = grayPix;
      MODE_PRIMARY: pix = primaryPix;
      MODE_RAINBOW: pix = rainbowPix;
      MODE_CHECKER: pix = checker1_q ? RGB4_WHITE : RGB4_BLACK;
      MODE_TRIBAND: begin
        case (band1_q)
          BAND_TOP: pix = grayPix;
          BAND_MID: pix = primaryPix;
          default:  pix = rainbowPix;
        endcase
      end
      default:      pix = RGB4_WHITE;
    endcase
  end

  always_comb begin
    rWide         = expandIntensity(pix.r);
    gWide         = expandIntensity(pix.g);
    bWide         = expandIntensity(pix.b);
    unusedExpBits = ^{rWide, gWide, bWide};
    r2_d          = '0;
    g2_d          = '0;
    b2_d          = '0;
    if (de1_q) begin
      r2_d = rWide[31 -: RGB_WIDTH];
      g2_d = gWide[31 -: RGB_WIDTH];
      b2_d = bWide[31 -: RGB_WIDTH];
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      vsyncHist_q  <= 1'b1;
      frameStart_q <= 1'b0;
      offset_q     <= '0;
      activeMode_q <= MODE_GRAY;
      frameCnt_q   <= '0;
    end else begin
      vsyncHist_q  <= vga_vsync;
      frameStart_q <= frameStart_d;
      offset_q     <= offset_d;
      activeMode_q <= activeMode_d;
      frameCnt_q   <= frameCnt_d;
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      xe1_q      <= '0;
      band1_q    <= BAND_TOP;
      checker1_q <= 1'b0;
      mode1_q    <= MODE_GRAY;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      de1_q      <= 1'b0;
      r2_q       <= '0;
      g2_q       <= '0;
      b2_q       <= '0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
      de2_q      <= 1'b0;
    end else begin
      xe1_q      <= xe1_d;
      band1_q    <= band1_d;
      checker1_q <= checker1_d;
      mode1_q    <= activeMode_q;
      hs1_q      <= vga_hsync;
      vs1_q      <= vga_vsync;
      de1_q      <= video_on;
      r2_q       <= r2_d;
      g2_q       <= g2_d;
      b2_q       <= b2_d;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      de2_q      <= de1_q;
    end
  end

  assign R         = r2_q;
  assign G         = g2_q;
  assign B         = b2_q;
  assign HSYNC     = hs2_q;
  assign VSYNC     = vs2_q;
  assign DISPLAY   = de2_q;
  assign frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: every pattern mode, sync delay, async reset and scroll wrap.
module tb_pattern_gen;

  logic        pixel_clk = 1'b0;
  logic        reset     = 1'b1;
  logic        vga_hsync = 1'b1;
  logic        vga_vsync = 1'b1;
  logic        video_on  = 1'b0;
  logic [9:0]  x_addr    = '0;
  logic [9:0]  y_addr    = '0;
  logic [2:0]  mode      = 3'd0;
  logic        scroll_en = 1'b0;
  logic [7:0]  R, G, B;
  logic        HSYNC, VSYNC, DISPLAY;
  logic [15:0] frame_cnt;

  int compared   = 0;
  int mismatched = 0;
  int expFrames  = 0;

  pattern_gen dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync),
    .video_on  (video_on),
    .x_addr    (x_addr),
    .y_addr    (y_addr),
    .mode      (mode),
    .scroll_en (scroll_en),
    .R         (R),
    .G         (G),
    .B         (B),
    .HSYNC     (HSYNC),
    .VSYNC     (VSYNC),
    .DISPLAY   (DISPLAY),
    .frame_cnt (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkPixel(input string tag, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b);
    checkOutput({tag, "_R"}, 32'(R), 32'(r));
    checkOutput({tag, "_G"}, 32'(G), 32'(g));
    checkOutput({tag, "_B"}, 32'(B), 32'(b));
  endtask

  // Holds one pixel on the inputs for the two-cycle pipeline.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic de, input logic hs);
    x_addr    = x;
    y_addr    = y;
    video_on  = de;
    vga_hsync = hs;
    tick();
    tick();
  endtask

  task automatic pulseFrame();
    vga_vsync = 1'b0;
    tick();
    tick();
    vga_vsync = 1'b1;
    tick();
    expFrames++;
  endtask

  initial begin
    tick();
    tick();
    checkPixel("reset_rgb", 8'h00, 8'h00, 8'h00);
    checkOutput("reset_hsync", 32'(HSYNC), 32'd1);
    checkOutput("reset_vsync", 32'(VSYNC), 32'd1);
    checkOutput("reset_display", 32'(DISPLAY), 32'd0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);

    reset = 1'b0;
    tick();

    applyStimulus(10'h1E0, 10'd0, 1'b1, 1'b1);
    checkPixel("gray_1e0", 8'hFF, 8'hFF, 8'hFF);
    checkOutput("gray_display", 32'(DISPLAY), 32'd1);
    applyStimulus(10'h0A0, 10'd0, 1'b1, 1'b1);
    checkPixel("gray_0a0", 8'h55, 8'h55, 8'h55);

    mode = 3'd1;
    pulseFrame();
    applyStimulus(10'h180, 10'd0, 1'b1, 1'b1);
    checkPixel("primary_180", 8'hFF, 8'hFF, 8'h00);
    applyStimulus(10'h140, 10'd0, 1'b1, 1'b1);
    checkPixel("primary_140", 8'hFF, 8'h00, 8'hFF);

    mode = 3'd2;
    pulseFrame();
    applyStimulus(10'h088, 10'd0, 1'b1, 1'b1);
    checkPixel("rainbow_088", 8'hEE, 8'hFF, 8'h00);
    applyStimulus(10'h218, 10'd0, 1'b1, 1'b1);
    checkPixel("rainbow_218", 8'h33, 8'h00, 8'hFF);
    applyStimulus(10'h000, 10'd0, 1'b1, 1'b1);
    checkPixel("rainbow_000", 8'hFF, 8'h00, 8'h00);

    mode = 3'd0;
    pulseFrame();
    mode = 3'd3;
    applyStimulus(10'd32, 10'd0, 1'b1, 1'b1);
    checkPixel("midframe_still_gray", 8'h11, 8'h11, 8'h11);
    pulseFrame();
    applyStimulus(10'd32, 10'd0, 1'b1, 1'b1);
    checkPixel("checker_32_0", 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(10'd32, 10'd32, 1'b1, 1'b1);
    checkPixel("checker_32_32", 8'h00, 8'h00, 8'h00);

    mode = 3'd4;
    pulseFrame();
    applyStimulus(10'h1E0, 10'd0, 1'b1, 1'b1);
    checkPixel("triband_top", 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(10'h140, 10'd200, 1'b1, 1'b1);
    checkPixel("triband_mid", 8'hFF, 8'h00, 8'hFF);
    applyStimulus(10'h088, 10'd400, 1'b1, 1'b1);
    checkPixel("triband_low", 8'hEE, 8'hFF, 8'h00);

    mode = 3'd6;
    pulseFrame();
    applyStimulus(10'd100, 10'd100, 1'b1, 1'b1);
    checkPixel("mode6_on", 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(10'd100, 10'd100, 1'b0, 1'b1);
    checkPixel("mode6_blank", 8'h00, 8'h00, 8'h00);
    checkOutput("blank_display", 32'(DISPLAY), 32'd0);

    vga_hsync = 1'b0;
    tick();
    checkOutput("hsync_delay1", 32'(HSYNC), 32'd1);
    tick();
    checkOutput("hsync_delay2", 32'(HSYNC), 32'd0);
    vga_vsync = 1'b0;
    tick();
    checkOutput("vsync_delay1", 32'(VSYNC), 32'd1);
    tick();
    checkOutput("vsync_delay2", 32'(VSYNC), 32'd0);
    vga_vsync = 1'b1;
    expFrames++;
    tick();
    tick();
    checkOutput("vsync_release", 32'(VSYNC), 32'd1);
    checkOutput("frame_cnt_count", 32'(frame_cnt), 32'(expFrames));

    applyStimulus(10'd100, 10'd100, 1'b1, 1'b0);
    checkPixel("prereset_white", 8'hFF, 8'hFF, 8'hFF);
    checkOutput("prereset_hsync", 32'(HSYNC), 32'd0);
    @(posedge pixel_clk);
    #3;
    reset = 1'b1;
    #1;
    checkPixel("async_reset_rgb", 8'h00, 8'h00, 8'h00);
    checkOutput("async_reset_hsync", 32'(HSYNC), 32'd1);
    checkOutput("async_reset_display", 32'(DISPLAY), 32'd0);
    checkOutput("async_reset_frame_cnt", 32'(frame_cnt), 32'd0);
    tick();
    reset     = 1'b0;
    mode      = 3'd0;
    expFrames = 0;
    tick();
    applyStimulus(10'h1E0, 10'd0, 1'b1, 1'b1);
    checkOutput("post_reset_frame_cnt", 32'(frame_cnt), 32'd0);
    checkPixel("post_reset_gray", 8'hFF, 8'hFF, 8'hFF);

    scroll_en = 1'b1;
    for (int i = 0; i < 161; i++) begin
      pulseFrame();
    end
    scroll_en = 1'b0;
    checkOutput("scroll_frame_cnt", 32'(frame_cnt), 32'd161);
    applyStimulus(10'h1DC, 10'd0, 1'b1, 1'b1);
    checkPixel("scroll_offset4", 8'hFF, 8'hFF, 8'hFF);
    applyStimulus(10'd636, 10'd0, 1'b1, 1'b1);
    checkPixel("scroll_wrap", 8'h00, 8'h00, 8'h00);
    pulseFrame();
    applyStimulus(10'h1DC, 10'd0, 1'b1, 1'b1);
    checkPixel("scroll_hold", 8'hFF, 8'hFF, 8'hFF);
    checkOutput("frame_cnt_final", 32'(frame_cnt), 32'(expFrames));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter RGB_WIDTH, default 8: output bits per colour channel, minimum 4.
REQ-002 Parameter SCROLL_STEP, default 4: pixels added to the scroll offset per frame.
REQ-003 Parameter CHECK_LOG2, default 5: checkerboard square edge is 2^CHECK_LOG2 pixels.
REQ-004 pixel_clk  input  1  sole clock; every register samples on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 vga_hsync, vga_vsync  input  1 each  timing syncs, active-low.
REQ-007 video_on  input  1  active display region.
REQ-008 x_addr, y_addr  input  `H_SIZE each  pixel coordinates.
REQ-009 mode  input  3  pattern select: 0 gray, 1 primary, 2 rainbow, 3 checker, 4 tri-band.
REQ-010 scroll_en  input  1  enables horizontal animation.
REQ-011 R, G, B  output  RGB_WIDTH each  pixel colour.
REQ-012 HSYNC, VSYNC, DISPLAY  output  1 each  delayed syncs and display enable.
REQ-013 frame_cnt  output  16  count of frame starts since reset.

Function
REQ-014 A frame start is a 1->0 transition of vga_vsync, detected against a registered copy of vga_vsync.
REQ-015 mode is latched into active_mode only at frame start; mid-frame changes take effect from the next frame.
REQ-016 On each frame start, frame_cnt increments by 1 and wraps from 0xFFFF to 0.
REQ-017 On each frame start with scroll_en=1, offset becomes (offset+SCROLL_STEP) mod `H_DISPLAY; with scroll_en=0, offset holds.
REQ-018 Effective x is xe=(x_addr+offset) mod `H_DISPLAY, computed without overflow at `H_SIZE+1 bits.
REQ-019 Gray (0): all channels = xe[8:5].
REQ-020 Primary (1): r=4{xe[8]}, g=4{xe[7]}, b=4{xe[6]}.
REQ-021 Rainbow (2): the segment is xe[9:7], and up=xe[6:3], dn=15-up. Segments 0..5 give (r,g,b) = (F,up,0), (dn,F,0), (0,F,up), (0,dn,F), (up,0,F), (F,0,dn). Segments 6-7 give white.
REQ-022 Checker (3): white when x_addr[CHECK_LOG2] XOR y_addr[CHECK_LOG2] is 1, else black; it does not scroll.
REQ-023 Tri-band (4): rows y<`V_DISPLAY/3 use gray, rows y<2*`V_DISPLAY/3 use primary, remaining rows use rainbow, all on xe.
REQ-024 active_mode values 5-7 produce white.
REQ-025 Each 4-bit intensity expands to RGB_WIDTH by MSB-first bit replication, truncated; F maps to all-ones and 0 maps to zero.
REQ-026 R carries r, G carries g, B carries b with no channel swap.
REQ-027 Pipeline is two stages. Stage 1 registers xe, the y band and the control flags. Stage 2 registers the colour.
REQ-028 Total latency is exactly 2 cycles from the inputs to R/G/B/HSYNC/VSYNC/DISPLAY.
REQ-029 HSYNC, VSYNC and DISPLAY are the inputs delayed 2 cycles, aligned with colour.
REQ-030 R/G/B are zero whenever the delayed DISPLAY is 0.
REQ-031 The frame start takes effect on the offset and active_mode one cycle after the detecting edge; pixels of the new frame begin well after this, so no partial-line artefact occurs.

Reset
REQ-032 While reset is high: R/G/B=0, HSYNC=1, VSYNC=1, DISPLAY=0, frame_cnt=0, offset=0, active_mode=0, and the vsync history register=1.
REQ-033 Reset asserted mid-frame clears everything immediately, with no spurious frame start counted on release.

Structure
REQ-034 A shared package holds the mode enumeration, the 4-bit colour triple struct and the intensity expand function; existing `H_SIZE/`H_DISPLAY/`V_DISPLAY come from vga.svh.
REQ-035 One sub-module, pattern_rainbow, maps (xe) to a 4-bit r/g/b triple combinationally.

Verification
REQ-036 Bench scenarios:
- Mode=0, scroll_en=0, xe=0x1E0: R=G=B=8'hFF two cycles later.
- Mode=2, x=0x088, offset 0: r=0xE, g=0xF, b=0; with RGB_WIDTH=8, R=8'hEE, G=8'hFF, B=8'h00.
- Scroll_en=1 for 161 frames with `H_DISPLAY=640: offset=644 mod 640=4, frame_cnt=161.
- Mode changes 0->3 mid-frame: pixels stay gray until the next vsync fall, then checkerboard; x=32,y=0 is white.
- video_on=0 pixels and mode=6 pixels: R/G/B=0 when blanked and all-ones when displayed; HSYNC/VSYNC match the inputs delayed 2 cycles.
- Reset pulsed mid-line: outputs go to reset values asynchronously; frame_cnt=0 after release until the next vsync fall.
